vga_sync_gen: RTL and testbench

Pixel-timing generator for the TinyVGA output path. Produces horizontal/vertical sync, the display-active flag and the current pixel coordinates for downstream pattern/colour logic, plus line/frame strobes and a free-running frame counter for animation. Defaults give 640x480@60 Hz at a 25.175 MHz (nominally 25 MHz) pixel clock. Each axis is a registered phase state machine with a position counter, so all outputs are glitch-free and mutually aligned.

---
 rtl/vga_timing_pkg.sv | 36 +++
 rtl/vga_sync_gen_if.sv | 25 ++
 rtl/vga_axis_counter.sv | 58 +++++
 rtl/vga_sync_gen.sv | 106 ++++++++++
 tb/tb_vga_sync_gen.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Shared timing constants and phase encoding for the VGA sync generator.
// Defaults describe 640x480@60 Hz at a 25.175 MHz pixel clock.
package vga_timing_pkg;

  localparam int unsigned POS_W = 10;
  typedef logic [POS_W-1:0] pos_t;

  localparam int unsigned H_DISPLAY_DEF = 640;
  localparam int unsigned H_FRONT_DEF   = 16;
  localparam int unsigned H_SYNC_DEF    = 96;
  localparam int unsigned H_BACK_DEF    = 48;
  localparam int unsigned V_DISPLAY_DEF = 480;
  localparam int unsigned V_FRONT_DEF   = 10;
  localparam int unsigned V_SYNC_DEF    = 2;
  localparam int unsigned V_BACK_DEF    = 33;

  function automatic int unsigned axis_total(input int unsigned display, input int unsigned front,
                                             input int unsigned sync, input int unsigned back);
    return display + front + sync + back;
  endfunction

  localparam int unsigned H_TOTAL = axis_total(H_DISPLAY_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF);
  localparam int unsigned V_TOTAL = axis_total(V_DISPLAY_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF);

  typedef logic [1:0] phase_t;
  localparam phase_t PH_ACTIVE = 2'd0;
  localparam phase_t PH_FRONT  = 2'd1;
  localparam phase_t PH_SYNC   = 2'd2;
  localparam phase_t PH_BACK   = 2'd3;

  // Pin level for a sync pulse given whether the pulse is active.
  function automatic logic sync_level(input logic active, input logic neg);
    return active ^ neg;
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Timing bundle between the sync generator (master) and pixel/colour logic (slave).
interface vga_sync_gen_if;
  import vga_timing_pkg::*;

  logic       ena;
  logic       hsync;
  logic       vsync;
  logic       display_on;
  pos_t       hpos;
  pos_t       vpos;
  logic       line_start;
  logic       frame_start;
  logic [9:0] frame_count;

  modport master (
    input  ena,
    output hsync, vsync, display_on, hpos, vpos, line_start, frame_start, frame_count
  );

  modport slave (
    output ena,
    input  hsync, vsync, display_on, hpos, vpos, line_start, frame_start, frame_count
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis: position counter plus ACTIVE/FRONT/SYNC/BACK phase register.
// Exposes the phase being loaded this edge so the parent can register aligned outputs.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned DISPLAY = H_DISPLAY_DEF,
  parameter int unsigned FRONT   = H_FRONT_DEF,
  parameter int unsigned SYNC    = H_SYNC_DEF,
  parameter int unsigned BACK    = H_BACK_DEF
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   step_i,
  output pos_t   pos_o,
  output phase_t state_next_o,
  output logic   wrap_o
);

  localparam int unsigned TOTAL = axis_total(DISPLAY, FRONT, SYNC, BACK);
  localparam pos_t LAST     = POS_W'(TOTAL - 1);
  localparam pos_t FRONT_AT = POS_W'(DISPLAY);
  localparam pos_t SYNC_AT  = POS_W'(DISPLAY + FRONT);
  localparam pos_t BACK_AT  = POS_W'(DISPLAY + FRONT + SYNC);

  pos_t   pos_q, pos_d;
  phase_t state_q, state_d;

  always_comb begin
    pos_d   = pos_q;
    state_d = state_q;
    if (step_i) begin
      pos_d = (pos_q == LAST) ? '0 : pos_q + POS_W'(1);
      // Phase decoded from the next position so it lands on the same edge as pos.
      case (state_q)
        PH_ACTIVE: if (pos_d == FRONT_AT) state_d = PH_FRONT;
        PH_FRONT:  if (pos_d == SYNC_AT)  state_d = PH_SYNC;
        PH_SYNC:   if (pos_d == BACK_AT)  state_d = PH_BACK;
        PH_BACK:   if (pos_d == '0)       state_d = PH_ACTIVE;
        default:   state_d = PH_ACTIVE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q   <= '0;
      state_q <= PH_ACTIVE;
    end else begin
      pos_q   <= pos_d;
      state_q <= state_d;
    end
  end

  assign pos_o        = pos_q;
  assign state_next_o = state_d;
  assign wrap_o       = (pos_q == LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA pixel-timing generator: sync, display-active, coordinates, strobes and frame counter.
// Every output is a flop loaded from next-state decode so all describe the same pixel.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_DISPLAY = H_DISPLAY_DEF,
  parameter int unsigned H_FRONT   = H_FRONT_DEF,
  parameter int unsigned H_SYNC    = H_SYNC_DEF,
  parameter int unsigned H_BACK    = H_BACK_DEF,
  parameter int unsigned V_DISPLAY = V_DISPLAY_DEF,
  parameter int unsigned V_FRONT   = V_FRONT_DEF,
  parameter int unsigned V_SYNC    = V_SYNC_DEF,
  parameter int unsigned V_BACK    = V_BACK_DEF,
  parameter bit          SYNC_NEG  = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  vga_sync_gen_if.master vga
);

  pos_t   h_pos, v_pos;
  phase_t h_state_d, v_state_d;
  logic   h_wrap, v_wrap;
  logic   v_step;

  assign v_step = vga.ena & h_wrap;

  vga_axis_counter #(
    .DISPLAY (H_DISPLAY),
    .FRONT   (H_FRONT),
    .SYNC    (H_SYNC),
    .BACK    (H_BACK)
  ) u_h_axis (
    .clk          (clk),
    .rst_n        (rst_n),
    .step_i       (vga.ena),
    .pos_o        (h_pos),
    .state_next_o (h_state_d),
    .wrap_o       (h_wrap)
  );

  vga_axis_counter #(
    .DISPLAY (V_DISPLAY),
    .FRONT   (V_FRONT),
    .SYNC    (V_SYNC),
    .BACK    (V_BACK)
  ) u_v_axis (
    .clk          (clk),
    .rst_n        (rst_n),
    .step_i       (v_step),
    .pos_o        (v_pos),
    .state_next_o (v_state_d),
    .wrap_o       (v_wrap)
  );

  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       display_on_q, display_on_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic [9:0] frame_count_q, frame_count_d;
  logic       vsync_on_q;

  assign vsync_on_q = vsync_q ^ SYNC_NEG;

  always_comb begin
    hsync_d       = sync_level(h_state_d == PH_SYNC, SYNC_NEG);
    vsync_d       = sync_level(v_state_d == PH_SYNC, SYNC_NEG);
    display_on_d  = (h_state_d == PH_ACTIVE) && (v_state_d == PH_ACTIVE);
    line_start_d  = vga.ena & h_wrap;
    frame_start_d = vga.ena & h_wrap & v_wrap;
    frame_count_d = frame_count_q;
    // Count on the rising edge of vsync activity; phases hold while ena is low.
    if ((v_state_d == PH_SYNC) && !vsync_on_q) begin
      frame_count_d = frame_count_q + 10'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q       <= SYNC_NEG;
      vsync_q       <= SYNC_NEG;
      display_on_q  <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      display_on_q  <= display_on_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.display_on  = display_on_q;
  assign vga.hpos        = h_pos;
  assign vga.vpos        = v_pos;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;
  assign vga.frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: default 640x480 timing, a mid-size timing for frame-level checks,
// and a tiny timing for frame_count wrap.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_na, rst_nb, rst_nc;

  vga_sync_gen_if a_if ();
  vga_sync_gen_if b_if ();
  vga_sync_gen_if c_if ();

  vga_sync_gen u_a (
    .clk   (clk),
    .rst_n (rst_na),
    .vga   (a_if)
  );

  // H 16/2/4/3 (total 25), V 12/2/2/3 (total 19): frame = 475 cycles.
  vga_sync_gen #(
    .H_DISPLAY (16), .H_FRONT (2), .H_SYNC (4), .H_BACK (3),
    .V_DISPLAY (12), .V_FRONT (2), .V_SYNC (2), .V_BACK (3)
  ) u_b (
    .clk   (clk),
    .rst_n (rst_nb),
    .vga   (b_if)
  );

  // H 4/1/2/1 (total 8), V 3/1/1/1 (total 6): frame = 48 cycles.
  vga_sync_gen #(
    .H_DISPLAY (4), .H_FRONT (1), .H_SYNC (2), .H_BACK (1),
    .V_DISPLAY (3), .V_FRONT (1), .V_SYNC (1), .V_BACK (1)
  ) u_c (
    .clk   (clk),
    .rst_n (rst_nc),
    .vga   (c_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int pos_err, first_dark, hs_cnt, hs_first, hs_last, ls_cnt, ls_h, ls_v, frz_err;
    int vs_cnt, vs_fh, vs_fv, vs_lh, vs_lv, hsb_cnt, fc1_h, fc1_v, fs_cnt, fs_i, fs_ls;
    int fs_first, wraps, wrap_i, prev_fc, cur_fc;

    rst_na = 1'b0;
    rst_nb = 1'b0;
    rst_nc = 1'b0;
    a_if.ena = 1'b1;
    b_if.ena = 1'b0;
    c_if.ena = 1'b0;
    step(3);

    check_eq("a_rst_hpos", int'(a_if.hpos), 0);
    check_eq("a_rst_vpos", int'(a_if.vpos), 0);
    check_eq("a_rst_display_on", int'(a_if.display_on), 1);
    check_eq("a_rst_hsync", int'(a_if.hsync), 1);
    check_eq("a_rst_vsync", int'(a_if.vsync), 1);
    check_eq("a_rst_frame_count", int'(a_if.frame_count), 0);

    rst_na = 1'b1;
    check_eq("a_c0_line_start", int'(a_if.line_start), 0);
    check_eq("a_c0_frame_start", int'(a_if.frame_start), 0);

    // First line of the default timing.
    pos_err = 0; first_dark = -1; hs_cnt = 0; hs_first = -1; hs_last = -1;
    ls_cnt = 0; ls_h = -1; ls_v = -1;
    for (int i = 1; i <= 800; i++) begin
      step(1);
      if (int'(a_if.hpos) != i % 800 || int'(a_if.vpos) != i / 800) pos_err++;
      if (!a_if.display_on && first_dark < 0) first_dark = int'(a_if.hpos);
      if (!a_if.hsync) begin
        if (hs_cnt == 0) hs_first = int'(a_if.hpos);
        hs_last = int'(a_if.hpos);
        hs_cnt++;
      end
      if (a_if.line_start) begin
        ls_cnt++;
        ls_h = int'(a_if.hpos);
        ls_v = int'(a_if.vpos);
      end
    end
    check_eq("a_pos_errors", pos_err, 0);
    check_eq("a_display_fall_hpos", first_dark, 640);
    check_eq("a_hsync_cycles", hs_cnt, 96);
    check_eq("a_hsync_first_hpos", hs_first, 656);
    check_eq("a_hsync_last_hpos", hs_last, 751);
    check_eq("a_line_start_count", ls_cnt, 1);
    check_eq("a_line_start_hpos", ls_h, 0);
    check_eq("a_line_start_vpos", ls_v, 1);
    check_eq("a_line1_display_on", int'(a_if.display_on), 1);

    // Freeze mid-line.
    step(300);
    check_eq("a_pre_freeze_hpos", int'(a_if.hpos), 300);
    a_if.ena = 1'b0;
    frz_err = 0;
    for (int i = 0; i < 37; i++) begin
      step(1);
      if (int'(a_if.hpos) != 300 || int'(a_if.vpos) != 1 || !a_if.display_on || !a_if.hsync ||
          !a_if.vsync || a_if.line_start || a_if.frame_start || a_if.frame_count != 10'd0)
        frz_err++;
    end
    check_eq("a_freeze_errors", frz_err, 0);
    a_if.ena = 1'b1;
    step(1);
    check_eq("a_resume_hpos", int'(a_if.hpos), 301);
    check_eq("a_resume_vpos", int'(a_if.vpos), 1);
    a_if.ena = 1'b0;

    // Full frame on the mid-size timing.
    b_if.ena = 1'b1;
    rst_nb = 1'b1;
    vs_cnt = 0; vs_fh = -1; vs_fv = -1; vs_lh = -1; vs_lv = -1; hsb_cnt = 0;
    fc1_h = -1; fc1_v = -1; fs_cnt = 0; fs_i = -1; fs_ls = -1;
    for (int i = 1; i <= 475; i++) begin
      step(1);
      if (!b_if.vsync) begin
        if (vs_cnt == 0) begin
          vs_fh = int'(b_if.hpos);
          vs_fv = int'(b_if.vpos);
        end
        vs_lh = int'(b_if.hpos);
        vs_lv = int'(b_if.vpos);
        vs_cnt++;
      end
      if (!b_if.hsync) hsb_cnt++;
      if (b_if.frame_count == 10'd1 && fc1_h < 0) begin
        fc1_h = int'(b_if.hpos);
        fc1_v = int'(b_if.vpos);
      end
      if (b_if.frame_start) begin
        fs_cnt++;
        fs_i  = i;
        fs_ls = int'(b_if.line_start);
      end
    end
    check_eq("b_vsync_cycles", vs_cnt, 50);
    check_eq("b_vsync_first_hpos", vs_fh, 0);
    check_eq("b_vsync_first_vpos", vs_fv, 14);
    check_eq("b_vsync_last_hpos", vs_lh, 24);
    check_eq("b_vsync_last_vpos", vs_lv, 15);
    check_eq("b_hsync_cycles", hsb_cnt, 76);
    check_eq("b_fc1_hpos", fc1_h, 0);
    check_eq("b_fc1_vpos", fc1_v, 14);
    check_eq("b_frame_start_count", fs_cnt, 1);
    check_eq("b_frame_start_cycle", fs_i, 475);
    check_eq("b_frame_start_with_line_start", fs_ls, 1);

    // Asynchronous reset in horizontal back porch during vsync of the second frame.
    step(398);
    check_eq("b_pre_rst_hpos", int'(b_if.hpos), 23);
    check_eq("b_pre_rst_vpos", int'(b_if.vpos), 15);
    check_eq("b_pre_rst_vsync", int'(b_if.vsync), 0);
    check_eq("b_pre_rst_frame_count", int'(b_if.frame_count), 2);
    #2;
    rst_nb = 1'b0;
    #1;
    check_eq("b_rst_hpos", int'(b_if.hpos), 0);
    check_eq("b_rst_vpos", int'(b_if.vpos), 0);
    check_eq("b_rst_vsync", int'(b_if.vsync), 1);
    check_eq("b_rst_hsync", int'(b_if.hsync), 1);
    check_eq("b_rst_display_on", int'(b_if.display_on), 1);
    check_eq("b_rst_frame_count", int'(b_if.frame_count), 0);
    check_eq("b_rst_strobes", int'(b_if.line_start) + int'(b_if.frame_start), 0);
    #1;
    rst_nb = 1'b1;
    fs_first = -1;
    for (int i = 1; i <= 600 && fs_first < 0; i++) begin
      step(1);
      if (i == 1) check_eq("b_post_rst_hpos", int'(b_if.hpos), 1);
      if (b_if.frame_start) fs_first = i;
    end
    check_eq("b_post_rst_frame_start_cycle", fs_first, 475);
    b_if.ena = 1'b0;

    // 1025 tiny frames: frame_count wraps 1023 -> 0, then reaches 1.
    c_if.ena = 1'b1;
    rst_nc = 1'b1;
    wraps = 0; wrap_i = -1; prev_fc = 0;
    for (int i = 1; i <= 49200; i++) begin
      step(1);
      cur_fc = int'(c_if.frame_count);
      if (prev_fc == 1023 && cur_fc == 0) begin
        wraps++;
        wrap_i = i;
      end
      prev_fc = cur_fc;
    end
    check_eq("c_wrap_count", wraps, 1);
    check_eq("c_wrap_cycle", wrap_i, 49136);
    check_eq("c_final_frame_count", int'(c_if.frame_count), 1);
    check_eq("c_final_hpos", int'(c_if.hpos), 0);
    check_eq("c_final_vpos", int'(c_if.vpos), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
